// File: rtl/tensor_core_pkg.sv
// Shared definitions for the tensor core MAC engine: FSM states, default
// geometry and the accumulator width used for exact dot products.
`timescale 1ns/1ps
package tensor_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int DEFAULT_DIM        = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Width that holds DIM full-precision products plus one addend without loss.
  function automatic int acc_width(input int data_width, input int dim);
    return 2 * data_width + $clog2(dim) + 1;
  endfunction

endpackage

// File: rtl/tensor_core_dot_product.sv
// Combinational row-by-column dot product with an optional addend, kept at
// full accumulator width so no precision is lost before the final reduction.
`timescale 1ns/1ps
module tensor_core_dot_product
  import tensor_core_pkg::*;
#(
  parameter int DIM        = DEFAULT_DIM,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_W      = acc_width(DEFAULT_DATA_WIDTH, DEFAULT_DIM)
) (
  input  logic signed [DATA_WIDTH-1:0] row_vec [DIM],
  input  logic signed [DATA_WIDTH-1:0] col_vec [DIM],
  input  logic signed [DATA_WIDTH-1:0] addend,
  input  logic                         add_en,
  output logic signed [ACC_W-1:0]      sum
);

  logic signed [2*DATA_WIDTH-1:0] prod [DIM];

  // Signed products at double width, sign-extended and summed at accumulator width.
  always_comb begin
    sum = add_en ? ACC_W'(addend) : '0;
    for (int i = 0; i < DIM; i++) begin
      prod[i] = row_vec[i] * col_vec[i];
      sum     = sum + ACC_W'(prod[i]);
    end
  end

endmodule

// File: rtl/tensor_core_mac_engine.sv
// Matrix multiply-accumulate engine: D = A*B (+C), one output element per
// cycle in row-major order after operands are captured on start.
// Optional feature: define TENSOR_CORE_SATURATE_EN to clamp each element to
// the signed DATA_WIDTH range; otherwise elements wrap to their low bits.
`timescale 1ns/1ps
module tensor_core_mac_engine
  import tensor_core_pkg::*;
#(
  parameter int DIM        = DEFAULT_DIM,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         start_in,
  input  logic                         accumulate_mode_in,
  input  logic signed [DATA_WIDTH-1:0] tensor_core_input1 [DIM][DIM],
  input  logic signed [DATA_WIDTH-1:0] tensor_core_input2 [DIM][DIM],
  input  logic signed [DATA_WIDTH-1:0] tensor_core_input3 [DIM][DIM],
  output logic signed [DATA_WIDTH-1:0] tensor_core_output [DIM][DIM],
  output logic                         busy,
  output logic                         is_done_with_calculation
);

  localparam int ACC_W = acc_width(DATA_WIDTH, DIM);
  localparam int IDX_W = $clog2(DIM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  state_e state_q, state_n;
  logic   capture, write_en, last_elem;

  logic [IDX_W-1:0] row_q, col_q;

  logic signed [DATA_WIDTH-1:0] a_p0 [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] b_p0 [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] c_p0 [DIM][DIM];
  logic                         mode_p0;

  logic signed [DATA_WIDTH-1:0] row_vec [DIM];
  logic signed [DATA_WIDTH-1:0] col_vec [DIM];
  logic signed [DATA_WIDTH-1:0] addend;
  logic signed [ACC_W-1:0]      sum_p1;

  // Reduce a full-width sum to an output element (clamp or two's-complement wrap).
  function automatic logic signed [DATA_WIDTH-1:0] reduce(input logic signed [ACC_W-1:0] s);
`ifdef TENSOR_CORE_SATURATE_EN
    if (s[ACC_W-1:DATA_WIDTH-1] != {(ACC_W-DATA_WIDTH+1){s[ACC_W-1]}})
      return s[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return s[DATA_WIDTH-1:0];
`else
    return s[DATA_WIDTH-1:0];
`endif
  endfunction

  assign last_elem                = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign busy                     = (state_q == ST_COMPUTE);
  assign is_done_with_calculation = (state_q == ST_DONE);

  // State register.
  always_ff @(posedge clock_in) begin
    if (reset_in) state_q <= ST_IDLE;
    else          state_q <= state_n;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_n  = state_q;
    capture  = 1'b0;
    write_en = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          capture = 1'b1;
          state_n = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        write_en = 1'b1;
        if (last_elem) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // ---- stage p0: operand capture (data only, no reset) ----
  // Snapshot operands and mode at the start edge; later input changes are ignored.
  always_ff @(posedge clock_in) begin
    if (capture) begin
      a_p0    <= tensor_core_input1;
      b_p0    <= tensor_core_input2;
      c_p0    <= tensor_core_input3;
      mode_p0 <= accumulate_mode_in;
    end
  end

  // Row-major element index: column is the fast counter.
  always_ff @(posedge clock_in) begin
    if (reset_in || capture) begin
      row_q <= '0;
      col_q <= '0;
    end else if (write_en && !last_elem) begin
      if (col_q == LAST_IDX) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Select the current row of A, column of B and element of C.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      row_vec[i] = a_p0[row_q][i];
      col_vec[i] = b_p0[i][col_q];
    end
    addend = c_p0[row_q][col_q];
  end

  tensor_core_dot_product #(
    .DIM        (DIM),
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W)
  ) u_dot (
    .row_vec (row_vec),
    .col_vec (col_vec),
    .addend  (addend),
    .add_en  (mode_p0),
    .sum     (sum_p1)
  );

  // ---- stage p1: reduce and write the indexed result element ----
  // Results clear on reset and on each new capture, so unwritten elements read 0.
  always_ff @(posedge clock_in) begin
    if (reset_in || capture) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          tensor_core_output[r][c] <= '0;
    end else if (write_en) begin
      tensor_core_output[row_q][col_q] <= reduce(sum_p1);
    end
  end

endmodule
